// File: rtl/vliw_pkg.sv
// Shared parameters, slot indices and unit latencies for the VLIW core.
// Used by the issue scoreboard and its per-register counters.
package vliw_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = $clog2(NUM_REGS);
    localparam int LAT_W    = 6;

    typedef enum logic [3:0] {
        SLOT_ADD0,
        SLOT_ADD1,
        SLOT_MUL,
        SLOT_FADD0,
        SLOT_FADD1,
        SLOT_FMUL,
        SLOT_LOGIC,
        SLOT_LDR,
        SLOT_STR,
        SLOT_MOV
    } slot_e;

    localparam int LAT_ADD   = 4;
    localparam int LAT_MUL   = 13;
    localparam int LAT_FADD  = 4;
    localparam int LAT_FMUL  = 26;
    localparam int LAT_LOGIC = 1;
    localparam int LAT_MEM   = 2;

endpackage

// File: rtl/sb_reg_counter.sv
// Remaining-latency countdown for one architectural register.
// retire is high in the last busy cycle, i.e. just before the 1->0 step.
module sb_reg_counter
    import vliw_pkg::*;
#(
    parameter int W = LAT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         last,
    output logic         retire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy   = (cnt != '0);
    assign last   = (cnt == W'(1));
    // A flushed counter clears silently instead of retiring.
    assign retire = last && !flush;

endmodule

// File: rtl/vliw_scoreboard.sv
// Issue-hazard scoreboard: per-register latency countdowns gate bundle issue.
// Build option SB_FWD_EN: a counter at 1 is readable (WB->EX bypass).
module vliw_scoreboard #(
    parameter int NUM_SLOTS = 10,
    parameter int NUM_REGS  = vliw_pkg::NUM_REGS,
    parameter int REG_W     = $clog2(NUM_REGS),
    parameter int LAT_W     = vliw_pkg::LAT_W,
    parameter int CNT_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [NUM_SLOTS-1:0]       slot_en,
    input  logic [NUM_SLOTS*REG_W-1:0] slot_dst,
    input  logic [NUM_SLOTS*REG_W-1:0] slot_src0,
    input  logic [NUM_SLOTS*REG_W-1:0] slot_src1,
    input  logic [NUM_SLOTS*LAT_W-1:0] slot_lat,
    output logic [NUM_REGS-1:0]        busy_vec,
    output logic [NUM_REGS-1:0]        retire_vec,
    output logic                       err_waw,
    output logic [CNT_W-1:0]           stall_cnt
);

    import vliw_pkg::*;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] last;
    logic [NUM_REGS-1:0] src_busy;
    logic [NUM_REGS-1:0] load;
    logic [LAT_W-1:0]    load_val [NUM_REGS];
    logic                conflict;
    logic                dup;
    logic                accept;

    assign busy[0]       = 1'b0;
    assign last[0]       = 1'b0;
    assign retire_vec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        sb_reg_counter #(.W(LAT_W)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .load     (accept && load[r]),
            .load_val (load_val[r]),
            .busy     (busy[r]),
            .last     (last[r]),
            .retire   (retire_vec[r])
        );
    end

`ifdef SB_FWD_EN
    assign src_busy = busy & ~last;
`else
    assign src_busy = busy;
`endif

    always_comb begin
        logic [REG_W-1:0] d, s0, s1;
        conflict = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            d  = slot_dst[i*REG_W +: REG_W];
            s0 = slot_src0[i*REG_W +: REG_W];
            s1 = slot_src1[i*REG_W +: REG_W];
            if (slot_en[i] && (src_busy[s0] || src_busy[s1] || busy[d]))
                conflict = 1'b1;
        end
    end

    assign issue_ready = !flush && !conflict;
    assign accept      = issue_valid && issue_ready;

    // Colliding destinations keep the longest latency; zero means one cycle.
    always_comb begin
        logic [REG_W-1:0] d;
        logic [LAT_W-1:0] l;
        load = '0;
        dup  = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) load_val[r] = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            d = slot_dst[i*REG_W +: REG_W];
            l = slot_lat[i*LAT_W +: LAT_W];
            if (l == '0) l = LAT_W'(1);
            if (slot_en[i] && d != '0) begin
                if (load[d]) begin
                    dup = 1'b1;
                    if (l > load_val[d]) load_val[d] = l;
                end else begin
                    load[d]     = 1'b1;
                    load_val[d] = l;
                end
            end
        end
    end

    assign busy_vec = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_waw   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            err_waw <= accept && dup;
            if (issue_valid && !issue_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
